// File: rtl/wrf_fabric_sink.sv
// WR fabric sink: accepts pipelined-Wishbone write beats, tags frame boundaries
// and status, and queues words in a show-ahead FIFO feeding a valid/ready stream.
module wrf_fabric_sink #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] snk_dat,
  input  logic [1:0]        snk_adr,
  input  logic [1:0]        snk_sel,
  input  logic              snk_cyc,
  input  logic              snk_stb,
  input  logic              snk_we,
  output logic              snk_ack,
  output logic              snk_stall,
  output logic              snk_err,
  output logic              snk_rty,
  output logic [DATA_W-1:0] out_dat,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_odd,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       frames_ok,
  output logic [15:0]       frames_bad
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W  = DATA_W + 4;
  localparam logic [ADDR_W+1:0] STALL_AT = (ADDR_W+2)'(FIFO_DEPTH - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FRAME = 1'b1} state_t;

  function automatic logic f_is_odd(input logic [1:0] sel);
    return (sel == 2'b10);
  endfunction

  state_t            r_state, w_state_nxt;
  logic              r_cyc, r_ack, r_err, r_flag, r_seen;
  logic              r_hold_vld, r_hold_first, r_hold_odd;
  logic [DATA_W-1:0] r_hold_dat;
  logic [15:0]       r_frames_ok, r_frames_bad;
  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W+1:0] w_claimed;
  logic              w_stall, w_start, w_end, w_active, w_accept, w_wr;
  logic              w_data_beat, w_status_beat, w_push, w_pop, w_valid;
  logic [ENT_W-1:0]  w_push_ent, w_head;

  // The held word already owns a FIFO slot, so it counts against free space.
  assign w_claimed     = {1'b0, r_count} + {{(ADDR_W+1){1'b0}}, r_hold_vld};
  assign w_stall       = (w_claimed >= STALL_AT);
  assign w_accept      = snk_cyc & snk_stb & ~w_stall;
  assign w_active      = (r_state == ST_FRAME) | w_start;
  assign w_wr          = w_accept & snk_we & w_active;
  assign w_data_beat   = w_wr & (snk_adr == 2'd0);
  assign w_status_beat = w_wr & (snk_adr == 2'd2);
  assign w_push        = r_hold_vld & (w_data_beat | w_end);
  assign w_push_ent    = w_end ? {r_hold_first, 1'b1, r_hold_odd, r_flag, r_hold_dat}
                               : {r_hold_first, 1'b0, 1'b0, 1'b0, r_hold_dat};
  assign w_valid       = (r_count != {(ADDR_W+1){1'b0}});
  assign w_pop         = w_valid & out_ready;
  assign w_head        = r_mem[r_rd_ptr];

  // Frame envelope FSM: next state plus start/end strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (snk_cyc && !r_cyc) begin
          w_start     = 1'b1;
          w_state_nxt = ST_FRAME;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FRAME: begin
        if (!snk_cyc && r_cyc) begin
          w_end       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_FRAME;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; cyc resets high so a frame still open at reset release is ignored.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cyc   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= snk_cyc;
    end
  end

  // Bus responses, one cycle after acceptance.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= w_accept & snk_we;
      r_err <= w_accept & ~snk_we;
    end
  end

  // Frame status flag and the one-word hold stage that lets eop be tagged late.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_flag       <= 1'b0;
      r_seen       <= 1'b0;
      r_hold_vld   <= 1'b0;
      r_hold_first <= 1'b0;
      r_hold_odd   <= 1'b0;
      r_hold_dat   <= {DATA_W{1'b0}};
    end else begin
      if (w_status_beat)   r_flag <= snk_dat[1];
      else if (w_start)    r_flag <= 1'b0;
      if (w_data_beat)     r_seen <= 1'b1;
      else if (w_start)    r_seen <= 1'b0;
      if (w_data_beat) begin
        r_hold_vld   <= 1'b1;
        r_hold_dat   <= snk_dat;
        r_hold_odd   <= f_is_odd(snk_sel);
        r_hold_first <= w_start | ~r_seen;
      end else if (w_end) begin
        r_hold_vld   <= 1'b0;
      end
    end
  end

  // Good/bad frame counters, bumped when the eop word is pushed.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_frames_ok  <= 16'd0;
      r_frames_bad <= 16'd0;
    end else if (w_end && r_hold_vld) begin
      if (r_flag) r_frames_bad <= r_frames_bad + 16'd1;
      else        r_frames_ok  <= r_frames_ok + 16'd1;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk_sys) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_ent;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {ADDR_W{1'b0}};
      r_rd_ptr <= {ADDR_W{1'b0}};
      r_count  <= {(ADDR_W+1){1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign snk_ack    = r_ack;
  assign snk_err    = r_err;
  assign snk_rty    = 1'b0;
  assign snk_stall  = w_stall;
  assign out_valid  = w_valid;
  assign out_dat    = w_valid ? w_head[DATA_W-1:0] : {DATA_W{1'b0}};
  assign out_sop    = w_valid & w_head[ENT_W-1];
  assign out_eop    = w_valid & w_head[ENT_W-2];
  assign out_odd    = w_valid & w_head[ENT_W-3];
  assign out_err    = w_valid & w_head[ENT_W-4];
  assign frames_ok  = r_frames_ok;
  assign frames_bad = r_frames_bad;

endmodule

// File: tb/tb_wrf_fabric_sink.sv
// Bench for wrf_fabric_sink: frame-level reference model feeds a scoreboard
// that a free-running monitor checks against the stream and bus responses.
module tb_wrf_fabric_sink;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] snk_dat;
  logic [1:0]    snk_adr, snk_sel;
  logic          snk_cyc, snk_stb, snk_we;
  logic          snk_ack, snk_stall, snk_err, snk_rty;
  logic [DW-1:0] out_dat;
  logic          out_sop, out_eop, out_odd, out_err, out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   frames_ok, frames_bad;

  int n_tests = 0;
  int n_fail  = 0;
  logic [19:0] exp_q[$];
  logic [1:0]  exp_resp = 2'b00;
  int ready_mode = 1;
  int data_acc = 0;
  int n_ok = 0;
  int n_bad = 0;
  logic [DW-1:0] fw [32];
  logic [1:0]    fs [32];

  always #5 clk = ~clk;

  wrf_fabric_sink #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_sys(clk), .rst_n(rst_n), .snk_dat(snk_dat), .snk_adr(snk_adr),
    .snk_sel(snk_sel), .snk_cyc(snk_cyc), .snk_stb(snk_stb), .snk_we(snk_we),
    .snk_ack(snk_ack), .snk_stall(snk_stall), .snk_err(snk_err), .snk_rty(snk_rty),
    .out_dat(out_dat), .out_sop(out_sop), .out_eop(out_eop), .out_odd(out_odd),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
    .frames_ok(frames_ok), .frames_bad(frames_bad)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Acceptance rule: a beat is taken on a clock edge with cyc & stb & !stall.
  initial forever begin
    @(posedge clk);
    if (rst_n && snk_cyc && snk_stb && !snk_stall) begin
      exp_resp = snk_we ? 2'b10 : 2'b01;
      if (snk_we && snk_adr == 2'd0) data_acc++;
    end else begin
      exp_resp = 2'b00;
    end
  end

  // Monitor: drives out_ready, then scores the word about to be popped and the response.
  initial forever begin
    logic [19:0] e;
    @(negedge clk);
    if (rst_n) begin
      case (ready_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL stream_unexpected: got %0h expected no word", out_dat);
        end else begin
          e = exp_q.pop_front();
          check("stream_word", {out_sop, out_eop, out_odd, out_err, out_dat}, e);
        end
      end
      if (exp_resp != 2'b00 || snk_ack || snk_err)
        check("ack_err", {snk_ack, snk_err}, exp_resp);
    end
  end

  task automatic beat(input logic we, input logic [1:0] adr, input logic [DW-1:0] dat,
                      input logic [1:0] sel);
    int w = 0;
    snk_stb = 1'b1; snk_we = we; snk_adr = adr; snk_dat = dat; snk_sel = sel;
    while (snk_stall && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (snk_stall) begin
      n_tests++;
      n_fail++;
      $display("FAIL stall_timeout: stall still %0d after %0d cycles", snk_stall, w);
    end
    @(negedge clk);
    snk_stb = 1'b0;
  endtask

  // Reference model: a frame of n data words yields n stream words, sop on the first,
  // eop/err/odd on the last; err is the last status bit1 written within the frame.
  task automatic frame(input int n, input int sp, input logic [DW-1:0] st, input bit extras);
    logic flag;
    flag = (sp >= 0) ? st[1] : 1'b0;
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == 0), (i == n - 1), (i == n - 1) && (fs[i] == 2'b10),
                       (i == n - 1) && flag, fw[i]});
    if (n > 0) begin
      if (flag) n_bad++;
      else      n_ok++;
    end
    snk_cyc = 1'b1;
    for (int i = 0; i <= n; i++) begin
      if (i == sp) beat(1'b1, 2'd2, st, 2'b11);
      if (extras && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       beat(1'b1, 2'd1, DW'($urandom), 2'b11);
          1:       beat(1'b1, 2'd3, DW'($urandom), 2'b11);
          default: beat(1'b0, 2'($urandom_range(0, 3)), 16'hFFFF, 2'b11);
        endcase
      end
      if (i < n) beat(1'b1, 2'd0, fw[i], fs[i]);
    end
    snk_cyc = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int base, c;
    rst_n = 1'b0; snk_cyc = 1'b0; snk_stb = 1'b0; snk_we = 1'b0;
    snk_adr = 2'd0; snk_sel = 2'b11; snk_dat = '0;
    #3;
    check("reset_outputs", {snk_ack, snk_stall, snk_err, snk_rty, out_sop, out_eop, out_odd,
                            out_err, out_valid, out_dat, frames_ok, frames_bad}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good three-word frame.
    fw[0] = 16'h1111; fw[1] = 16'h2222; fw[2] = 16'h3333;
    fs[0] = 2'b11; fs[1] = 2'b11; fs[2] = 2'b11;
    frame(3, 0, 16'h0000, 1'b0);
    drain();
    check("frames_ok_1", frames_ok, 64'd1);

    // Bad single-word odd frame.
    fw[0] = 16'hAAAA; fs[0] = 2'b10;
    frame(1, 0, 16'h0002, 1'b0);
    drain();
    check("frames_bad_1", frames_bad, 64'd1);

    // Read beat and a data-less frame: responses only, nothing pushed.
    snk_cyc = 1'b1;
    beat(1'b0, 2'd0, 16'h5555, 2'b11);
    beat(1'b1, 2'd1, 16'h1234, 2'b11);
    snk_cyc = 1'b0;
    repeat (4) @(negedge clk);
    check("read_no_push", out_valid, 64'd0);
    check("read_no_count", {frames_ok, frames_bad}, {16'd1, 16'd1});

    // Backpressure: 20-word frame with a stalled consumer.
    ready_mode = 2;
    for (int i = 0; i < 20; i++) begin fw[i] = DW'($urandom); fs[i] = 2'b11; end
    base = data_acc;
    fork
      frame(20, -1, 16'h0000, 1'b0);
      begin
        c = 0;
        while (!snk_stall && c < 400) begin @(negedge clk); c++; end
        check("stall_data_beats", 64'(data_acc - base), 64'd15);
        repeat (10) @(negedge clk);
        check("stall_held", snk_stall, 64'd1);
        ready_mode = 1;
      end
    join
    drain();

    // Back-to-back single-word frames.
    for (int f = 0; f < 10; f++) begin
      fw[0] = DW'($urandom); fs[0] = 2'b11;
      frame(1, -1, 16'h0000, 1'b0);
    end
    drain();
    check("b2b_frames_ok", frames_ok, 64'(n_ok));

    // Randomised frames with random consumer readiness.
    ready_mode = 0;
    for (int f = 0; f < 30; f++) begin
      int n, sp;
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin fw[i] = DW'($urandom); fs[i] = 2'($urandom_range(0, 3)); end
      sp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n)) : -1;
      frame(n, sp, DW'($urandom), 1'b1);
    end
    drain();
    check("rand_frames_ok", frames_ok, 64'(n_ok));
    check("rand_frames_bad", frames_bad, 64'(n_bad));

    // Reset in the middle of a frame discards it.
    ready_mode = 2;
    snk_cyc = 1'b1;
    beat(1'b1, 2'd0, 16'hBEEF, 2'b11);
    beat(1'b1, 2'd0, 16'hCAFE, 2'b11);
    beat(1'b1, 2'd0, 16'hF00D, 2'b11);
    repeat (2) @(negedge clk);
    check("pre_reset_valid", out_valid, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs", {snk_ack, snk_stall, snk_err, snk_rty, out_sop, out_eop, out_odd,
                               out_err, out_valid, out_dat, frames_ok, frames_bad}, 64'd0);
    snk_cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_valid", out_valid, 64'd0);
    check("post_reset_counts", {frames_ok, frames_bad}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
